// File: rtl/multicycle_control.sv
// multicycle_control
// ------------------
// Multi-cycle sequencer for the MIPS datapath. One instruction at a time is
// walked through fetch, decode, execute, memory and write-back. The single ALU
// and the single memory port are shared across those cycles.
//
// Outputs are a combinational decode of the current state. In FETCH and
// BRANCH they also depend on memory_ready or zero. Because the state register
// resets asynchronously, every output drops to 0 as soon as reset rises.
//
// Optional feature: define MULTICYCLE_PERF_COUNTER_EN to add the free-running
// cycle_count and retired_count performance counters. Leaving it undefined
// removes those ports and counters; the FSM behaves the same either way.

module multicycle_control (
   input  logic        system_clock,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        memory_ready,
   output logic        pc_write,
   output logic [1:0]  pc_source,
   output logic        instruction_register_write,
   output logic        i_or_d,
   output logic        memory_read,
   output logic        memory_write,
   output logic        alu_source_a,
   output logic [1:0]  alu_source_b,
   output logic [1:0]  alu_opcode,
   output logic        register_destination,
   output logic        memory_to_register,
   output logic        register_write,
   output logic        illegal_opcode,
   output logic [3:0]  state
`ifdef MULTICYCLE_PERF_COUNTER_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] retired_count
`endif
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      EXECUTE   = 4'd7,
      R_WB      = 4'd8,
      BRANCH    = 4'd9,
      JUMP      = 4'd10,
      ADDI_EX   = 4'd11,
      ADDI_WB   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t     current_state;
   logic [5:0] opcode_q;

   assign state = current_state;

   // Sequencer. The opcode is captured only in DECODE, so the later states
   // (lw/sw split, beq/bne test) ignore anything the instruction register
   // does afterwards. The memory states hold until memory_ready is seen.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         current_state <= IDLE;
         opcode_q      <= 6'd0;
      end else begin
         case (current_state)
            IDLE: current_state <= FETCH;
            FETCH: begin
               if (memory_ready)
                  current_state <= DECODE;
            end
            DECODE: begin
               opcode_q <= opcode;
               case (opcode)
                  OP_RTYPE:       current_state <= EXECUTE;
                  OP_LW, OP_SW:   current_state <= MEM_ADDR;
                  OP_BEQ, OP_BNE: current_state <= BRANCH;
                  OP_J:           current_state <= JUMP;
                  OP_ADDI:        current_state <= ADDI_EX;
                  default:        current_state <= FETCH;
               endcase
            end
            MEM_ADDR: begin
               if (opcode_q == OP_SW)
                  current_state <= MEM_WRITE;
               else
                  current_state <= MEM_READ;
            end
            MEM_READ: begin
               if (memory_ready)
                  current_state <= MEM_WB;
            end
            MEM_WB: current_state <= FETCH;
            MEM_WRITE: begin
               if (memory_ready)
                  current_state <= FETCH;
            end
            EXECUTE: current_state <= R_WB;
            R_WB:    current_state <= FETCH;
            BRANCH:  current_state <= FETCH;
            JUMP:    current_state <= FETCH;
            ADDI_EX: current_state <= ADDI_WB;
            ADDI_WB: current_state <= FETCH;
            default: current_state <= IDLE;
         endcase
      end
   end

   // Datapath steering. Every strobe defaults to 0; each state raises only
   // what it needs. FETCH loads the PC and IR on the same cycle that memory
   // delivers the instruction. PC+4 comes from the ALU.
   always_comb begin
      pc_write                   = 1'b0;
      pc_source                  = 2'b00;
      instruction_register_write = 1'b0;
      i_or_d                     = 1'b0;
      memory_read                = 1'b0;
      memory_write               = 1'b0;
      alu_source_a               = 1'b0;
      alu_source_b               = 2'b00;
      alu_opcode                 = 2'b00;
      register_destination       = 1'b0;
      memory_to_register         = 1'b0;
      register_write             = 1'b0;
      illegal_opcode             = 1'b0;
      case (current_state)
         FETCH: begin
            memory_read                = 1'b1;
            alu_source_b               = 2'b01;
            pc_write                   = memory_ready;
            instruction_register_write = memory_ready;
         end
         DECODE: begin
            alu_source_b = 2'b11;
            case (opcode)
               OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI:
                  illegal_opcode = 1'b0;
               default:
                  illegal_opcode = 1'b1;
            endcase
         end
         MEM_ADDR: begin
            alu_source_a = 1'b1;
            alu_source_b = 2'b10;
         end
         MEM_READ: begin
            memory_read = 1'b1;
            i_or_d      = 1'b1;
         end
         MEM_WB: begin
            register_write     = 1'b1;
            memory_to_register = 1'b1;
         end
         MEM_WRITE: begin
            memory_write = 1'b1;
            i_or_d       = 1'b1;
         end
         EXECUTE: begin
            alu_source_a = 1'b1;
            alu_opcode   = 2'b10;
         end
         R_WB: begin
            register_write       = 1'b1;
            register_destination = 1'b1;
         end
         BRANCH: begin
            alu_source_a = 1'b1;
            alu_opcode   = 2'b01;
            pc_source    = 2'b01;
            pc_write     = ((opcode_q == OP_BEQ) && zero) ||
                           ((opcode_q == OP_BNE) && !zero);
         end
         JUMP: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
         end
         ADDI_EX: begin
            alu_source_a = 1'b1;
            alu_source_b = 2'b10;
         end
         ADDI_WB: begin
            register_write = 1'b1;
         end
         default: begin
            pc_write = 1'b0;
         end
      endcase
   end

`ifdef MULTICYCLE_PERF_COUNTER_EN
   logic retiring;

   // An instruction retires when its final state hands back to FETCH.
   // Illegal opcodes return from DECODE and are not counted.
   always_comb begin
      retiring = 1'b0;
      case (current_state)
         MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: retiring = 1'b1;
         MEM_WRITE:                           retiring = memory_ready;
         default:                             retiring = 1'b0;
      endcase
   end

   // Free-running performance counters. Both wrap naturally at 32 bits.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         cycle_count   <= 32'd0;
         retired_count <= 32'd0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (retiring)
            retired_count <= retired_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// ---------------------
// Bench for multicycle_control. The expected behaviour is built one
// instruction at a time, as the sequence of cycles that instruction should
// take. Each cycle carries the expected state code and control vector, and
// each sequence starts from the opcode, the wait counts and the zero flag.
// Inputs the DUT should ignore are driven randomly.

module tb_multicycle_control;

   logic        system_clock;
   logic        reset;
   logic [5:0]  opcode;
   logic        zero;
   logic        memory_ready;
   logic        pc_write;
   logic [1:0]  pc_source;
   logic        instruction_register_write;
   logic        i_or_d;
   logic        memory_read;
   logic        memory_write;
   logic        alu_source_a;
   logic [1:0]  alu_source_b;
   logic [1:0]  alu_opcode;
   logic        register_destination;
   logic        memory_to_register;
   logic        register_write;
   logic        illegal_opcode;
   logic [3:0]  state;
`ifdef MULTICYCLE_PERF_COUNTER_EN
   logic [31:0] cycle_count;
   logic [31:0] retired_count;
`endif

   logic [15:0] ctrl_obs;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int model_clocks  = 0;
   int model_retired = 0;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   multicycle_control dut (
      .system_clock               (system_clock),
      .reset                      (reset),
      .opcode                     (opcode),
      .zero                       (zero),
      .memory_ready               (memory_ready),
      .pc_write                   (pc_write),
      .pc_source                  (pc_source),
      .instruction_register_write (instruction_register_write),
      .i_or_d                     (i_or_d),
      .memory_read                (memory_read),
      .memory_write               (memory_write),
      .alu_source_a               (alu_source_a),
      .alu_source_b               (alu_source_b),
      .alu_opcode                 (alu_opcode),
      .register_destination       (register_destination),
      .memory_to_register         (memory_to_register),
      .register_write             (register_write),
      .illegal_opcode             (illegal_opcode),
      .state                      (state)
`ifdef MULTICYCLE_PERF_COUNTER_EN
      ,
      .cycle_count                (cycle_count),
      .retired_count              (retired_count)
`endif
   );

   assign ctrl_obs = {pc_write, pc_source, instruction_register_write, i_or_d,
                      memory_read, memory_write, alu_source_a, alu_source_b,
                      alu_opcode, register_destination, memory_to_register,
                      register_write, illegal_opcode};

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial system_clock = 1'b0;
   always #5 system_clock = ~system_clock;

   function automatic logic [15:0] pack(input logic pcw, input logic [1:0] pcs,
                                        input logic irw, input logic iord,
                                        input logic mrd, input logic mwr,
                                        input logic asa, input logic [1:0] asb,
                                        input logic [1:0] aop, input logic rdst,
                                        input logic m2r, input logic rw,
                                        input logic ill);
      return {pcw, pcs, irw, iord, mrd, mwr, asa, asb, aop, rdst, m2r, rw, ill};
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom);
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) ||
             (op == OP_ADDI);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check at the falling edge, advance.
   task automatic apply_stimulus(input logic [3:0] exp_state,
                                 input logic [15:0] exp_ctrl,
                                 input logic mr, input logic z,
                                 input logic [5:0] op, input string tag);
      memory_ready = mr;
      zero         = z;
      opcode       = op;
      @(negedge system_clock);
      check_output({tag, " state"}, 32'(state), 32'(exp_state));
      check_output({tag, " ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl));
      @(posedge system_clock);
      #1;
      model_clocks++;
   endtask

   task automatic check_counters(input string tag);
`ifdef MULTICYCLE_PERF_COUNTER_EN
      check_output({tag, " cycle_count"}, cycle_count, 32'(model_clocks));
      check_output({tag, " retired_count"}, retired_count, 32'(model_retired));
`else
      if (tag.len() < 0) $display("[TB] %s", tag);
`endif
   endtask

   task automatic release_reset();
      @(posedge system_clock);
      #1;
      reset = 1'b0;
      model_clocks  = 0;
      model_retired = 0;
      apply_stimulus(4'd0, 16'd0, rb(), rb(), rop(), "idle");
   endtask

   task automatic fetch_phase(input int waits);
      for (int i = 0; i < waits; i++)
         apply_stimulus(4'd1, pack(0, 2'd0, 0, 0, 1, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0),
                        1'b0, rb(), rop(), "fetch wait");
      apply_stimulus(4'd1, pack(1, 2'd0, 1, 0, 1, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0),
                     1'b1, rb(), rop(), "fetch");
   endtask

   task automatic decode_phase(input logic [5:0] op);
      apply_stimulus(4'd2, pack(0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 0, 0, 0,
                                !is_legal(op)),
                     rb(), rb(), op, "decode");
   endtask

   // Full instruction, from its FETCH to the next FETCH.
   task automatic run_instr(input logic [5:0] op, input int fwaits,
                            input int mwaits, input logic z);
      logic taken;
      fetch_phase(fwaits);
      decode_phase(op);
      case (op)
         OP_LW: begin
            apply_stimulus(4'd3, pack(0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0, 0),
                           rb(), rb(), rop(), "lw addr");
            for (int i = 0; i < mwaits; i++)
               apply_stimulus(4'd4, pack(0, 2'd0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0),
                              1'b0, rb(), rop(), "lw read wait");
            apply_stimulus(4'd4, pack(0, 2'd0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0),
                           1'b1, rb(), rop(), "lw read");
            apply_stimulus(4'd5, pack(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 0),
                           rb(), rb(), rop(), "lw wb");
         end
         OP_SW: begin
            apply_stimulus(4'd3, pack(0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0, 0),
                           rb(), rb(), rop(), "sw addr");
            for (int i = 0; i < mwaits; i++)
               apply_stimulus(4'd6, pack(0, 2'd0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0),
                              1'b0, rb(), rop(), "sw write wait");
            apply_stimulus(4'd6, pack(0, 2'd0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0),
                           1'b1, rb(), rop(), "sw write");
         end
         OP_RTYPE: begin
            apply_stimulus(4'd7, pack(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0, 0, 0, 0),
                           rb(), rb(), rop(), "r execute");
            apply_stimulus(4'd8, pack(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 0),
                           rb(), rb(), rop(), "r wb");
         end
         OP_BEQ, OP_BNE: begin
            taken = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);
            apply_stimulus(4'd9, pack(taken, 2'd1, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0, 0, 0),
                           rb(), z, rop(), "branch");
         end
         OP_J: begin
            apply_stimulus(4'd10, pack(1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0),
                           rb(), rb(), rop(), "jump");
         end
         OP_ADDI: begin
            apply_stimulus(4'd11, pack(0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0, 0),
                           rb(), rb(), rop(), "addi execute");
            apply_stimulus(4'd12, pack(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 1, 0),
                           rb(), rb(), rop(), "addi wb");
         end
         default: begin
         end
      endcase
      if (is_legal(op))
         model_retired++;
      check_counters("after instr");
   endtask

   // Directed sequence followed by randomized instruction traffic.
   initial begin
      logic [5:0] legal_ops [7];
      logic [5:0] op;
      legal_ops[0] = OP_RTYPE; legal_ops[1] = OP_LW;  legal_ops[2] = OP_SW;
      legal_ops[3] = OP_BEQ;   legal_ops[4] = OP_BNE; legal_ops[5] = OP_J;
      legal_ops[6] = OP_ADDI;

      reset        = 1'b1;
      opcode       = 6'd0;
      zero         = 1'b0;
      memory_ready = 1'b0;
      #2;
      check_output("reset state", 32'(state), 32'd0);
      check_output("reset ctrl", 32'(ctrl_obs), 32'd0);
      release_reset();

      run_instr(OP_RTYPE, 0, 0, rb());
      run_instr(OP_LW, 1, 3, rb());
      run_instr(OP_BEQ, 0, 0, 1'b1);
      run_instr(OP_BNE, 0, 0, 1'b1);
      run_instr(OP_BEQ, 0, 0, 1'b0);
      run_instr(OP_BNE, 0, 0, 1'b0);
      run_instr(OP_BAD, 0, 0, rb());
      run_instr(OP_SW, 0, 2, rb());
      run_instr(OP_ADDI, 2, 0, rb());
      run_instr(OP_J, 0, 0, rb());

      // Reset in the middle of a stalled store.
      fetch_phase(0);
      decode_phase(OP_SW);
      apply_stimulus(4'd3, pack(0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0, 0),
                     rb(), rb(), rop(), "sw addr");
      memory_ready = 1'b0;
      #2;
      check_output("mid write state", 32'(state), 32'd6);
      check_output("mid write strobe", 32'(memory_write), 32'd1);
      reset = 1'b1;
      #1;
      check_output("async reset state", 32'(state), 32'd0);
      check_output("async reset ctrl", 32'(ctrl_obs), 32'd0);
      model_clocks  = 0;
      model_retired = 0;
      check_counters("async reset");
      release_reset();

      run_instr(OP_J, 0, 0, rb());
      run_instr(OP_ADDI, 0, 0, rb());
      run_instr(OP_BAD, 0, 0, rb());
`ifdef MULTICYCLE_PERF_COUNTER_EN
      check_output("seq retired_count", retired_count, 32'd2);
      check_output("seq cycle_count", cycle_count, 32'd10);
`endif

      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 7) == 7)
            op = rop();
         else
            op = legal_ops[$urandom_range(0, 6)];
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS datapath: a Moore/Mealy FSM that drives one instruction at a time through fetch, decode, execute, memory and write-back, sharing a single ALU and single memory port across cycles. Sits beside `control`/`arithmetic_logic_unit_control`: consumes the instruction-register opcode, ALU zero flag and a memory ready handshake; emits all datapath steering and write strobes.

## Interface
- No parameters.
- `system_clock` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: instruction[31:26] from instruction register.
- `zero` in 1: ALU zero output.
- `memory_ready` in 1: memory completes the current read/write this cycle.
- `pc_write` out 1: PC load strobe.
- `pc_source` out 2: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- `instruction_register_write` out 1: IR load strobe.
- `i_or_d` out 1: memory address 0=PC, 1=ALUOut.
- `memory_read`, `memory_write` out 1 each.
- `alu_source_a` out 1: 0=PC, 1=register A.
- `alu_source_b` out 2: 00 register B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `alu_opcode` out 2: 00 add, 01 subtract, 10 function field.
- `register_destination`, `memory_to_register`, `register_write` out 1 each.
- `illegal_opcode` out 1: one-cycle pulse.
- `state` out 4: current state encoding.

## Operation
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12. Unused codes → IDLE.
- Outputs are combinational decode of `state` (plus `memory_ready`/`zero` where stated); any output not listed for a state is 0.
- IDLE: all outputs 0; → FETCH.
- FETCH: memory_read=1, i_or_d=0, alu_source_b=01, alu_opcode=00, pc_source=00; pc_write=instruction_register_write=memory_ready. Stays until memory_ready=1, then → DECODE.
- DECODE: alu_source_b=11, alu_opcode=00 (branch target into ALUOut); opcode latched internally into opcode_q. Dispatch: 000000→EXECUTE, 100011/101011→MEM_ADDR, 000100/000101→BRANCH, 000010→JUMP, 001000→ADDI_EX, other→FETCH with illegal_opcode=1 for this cycle, no writes.
- MEM_ADDR: alu_source_a=1, alu_source_b=10, alu_opcode=00; → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: memory_read=1, i_or_d=1; waits on memory_ready, then → MEM_WB.
- MEM_WB: register_write=1, memory_to_register=1, register_destination=0; → FETCH.
- MEM_WRITE: memory_write=1, i_or_d=1; waits on memory_ready, then → FETCH.
- EXECUTE: alu_source_a=1, alu_source_b=00, alu_opcode=10; → R_WB. R_WB: register_write=1, register_destination=1; → FETCH.
- BRANCH: alu_source_a=1, alu_source_b=00, alu_opcode=01, pc_source=01; pc_write=(beq&zero)|(bne&!zero) per opcode_q; → FETCH.
- JUMP: pc_source=10, pc_write=1; → FETCH.
- ADDI_EX: alu_source_a=1, alu_source_b=10, alu_opcode=00; → ADDI_WB. ADDI_WB: register_write=1, register_destination=0; → FETCH.

## Timing
- Reset (async): state=IDLE, opcode_q=0; all outputs 0 immediately, including mid-memory-write. First FETCH one cycle after reset release.
- Zero-wait cycle counts (FETCH to next FETCH): lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- Each memory wait cycle adds one; strobes and address held stable while waiting.
- memory_ready ignored outside FETCH/MEM_READ/MEM_WRITE.
- opcode sampled only in DECODE; changes elsewhere have no effect.

## Configuration
- `MULTICYCLE_PERF_COUNTER_EN` defined: adds outputs `cycle_count` (32) and `retired_count` (32), reset to 0. cycle_count +1 every clock out of reset; retired_count +1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB (not from DECODE/IDLE). Both wrap 0xFFFFFFFF→0.
- Undefined: ports and counters absent; FSM behaviour identical.

## Test plan
- Reset then memory_ready=1, opcode=000000 → states 0,1,2,7,8,1; register_write=1 and register_destination=1 only in R_WB.
- lw (100011) with memory_ready low 3 cycles in MEM_READ → MEM_READ held 4 cycles, memory_read=1,i_or_d=1 stable; MEM_WB asserts register_write,memory_to_register.
- beq zero=1 → pc_write=1,pc_source=01 in BRANCH; bne zero=1 → pc_write=0.
- opcode=111111 → DECODE pulses illegal_opcode 1 cycle, back to FETCH, no register_write/memory_write.
- reset asserted mid MEM_WRITE → memory_write drops same cycle, state=0, counters 0.
- With MULTICYCLE_PERF_COUNTER_EN: j, addi, illegal sequence, zero-wait → retired_count=2, cycle_count=number of clocks since reset release.
